// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: per-channel FSM state
// encodings, board clock rate and default debounce/auto-repeat timing.
package input_conditioner_pkg;

  // Bit 1 of the encoding is the accepted level of the channel.
  typedef enum logic [1:0] {
    ST_LOW   = 2'b00,
    ST_CHK_H = 2'b01,
    ST_HIGH  = 2'b10,
    ST_CHK_L = 2'b11
  } db_state_e;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Converts a duration in milliseconds into CLOCK_50 cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // True in the states where the debounced level is 1.
  function automatic logic is_level_high(input db_state_e st);
    return (st == ST_HIGH) || (st == ST_CHK_L);
  endfunction

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = ms_to_cycles(20);   // 1_000_000
  localparam int unsigned DEF_CNT_W         = 20;
  localparam int unsigned DEF_REPEAT_DELAY  = ms_to_cycles(500);  // 25_000_000
  localparam int unsigned DEF_REPEAT_PERIOD = ms_to_cycles(100);  // 5_000_000
  localparam int unsigned DEF_REP_W         = 25;

endpackage

// File: rtl/input_conditioner_channel.sv
// debounce_channel: one synchroniser chain, debounce FSM with stability
// counter, registered level/rise/fall outputs and, when AUTO_REPEAT_EN is
// defined, a hold-to-repeat counter that adds extra pulses on press.
// Without AUTO_REPEAT_EN, press is identical to rise.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned REP_W         = DEF_REP_W
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debounce_channel: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2 || (STABLE_CYCLES >> CNT_W) != 0) begin : g_chk_cnt
    $error("debounce_channel: need STABLE_CYCLES >= 2 and 2**CNT_W > STABLE_CYCLES");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD ||
      (REPEAT_DELAY >> REP_W) != 0) begin : g_chk_rep
    $error("debounce_channel: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY < 2**REP_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, rise_q, fall_q;
  logic                   level_d, rise_d, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: a new level is accepted only after s has held it for
  // STABLE_CYCLES consecutive cycles; any bounce returns to the old level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_CHK_H;
          cnt_d   = '0;
        end
      end
      ST_CHK_H: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_CHK_L;
          cnt_d   = '0;
        end
      end
      ST_CHK_L: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
    level_d = is_level_high(state_d);
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef AUTO_REPEAT_EN
  // rep sits at 0 outside HIGH/CHK_L, so it starts from 0 on every rise.
  // After the first pulse it reloads to DELAY-PERIOD, which places every
  // later pulse REPEAT_PERIOD cycles apart on the same terminal compare.
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] rep_q;
  logic             rep_pulse;
  logic             press_q;

  assign rep_pulse = is_level_high(state_q) && (rep_q == REP_LAST);

  // Hold-time counter for auto-repeat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     rep_q <= '0;
    else if (!is_level_high(state_q)) rep_q <= '0;
    else if (rep_pulse)               rep_q <= REP_RELOAD;
    else                              rep_q <= rep_q + REP_W'(1);
  end

  // press combines the debounced rise with repeat pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) press_q <= 1'b0;
    else          press_q <= rise_d | rep_pulse;
  end

  assign press = press_q;
`else
  assign press = rise_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces a bus of WIDTH independent
// raw switch/key inputs, giving clean levels and single-cycle edge pulses.
// Optional auto-repeat on press is enabled by defining AUTO_REPEAT_EN.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned REP_W         = DEF_REP_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] press
);

  // One fully independent conditioner per channel.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REP_W        (REP_W)
    ) u_chan (
      .clock  (clock),
      .reset_n(reset_n),
      .raw_in (raw_in[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .press  (press[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short timing constants
// (WIDTH=2, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expected press pattern depends on whether AUTO_REPEAT_EN is defined.
module tb_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] raw_in;
  logic [1:0] level, rise, fall, press;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [1:0] seen_level, seen_rise, seen_fall;

  always #5 clock = ~clock;

  input_conditioner #(
    .WIDTH        (2),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (3),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .REP_W        (5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (raw_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .press  (press)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Advance n edges while OR-ing every output into the seen_* flags.
  task automatic tick_watch(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
      seen_level = seen_level | level;
      seen_rise  = seen_rise  | rise;
      seen_fall  = seen_fall  | fall;
    end
  endtask

  task automatic clear_seen();
    seen_level = '0;
    seen_rise  = '0;
    seen_fall  = '0;
  endtask

  function automatic logic exp_press1(input int e);
`ifdef AUTO_REPEAT_EN
    return (e == 7) || (e >= 17 && e <= 47 && ((e - 17) % 3) == 0);
`else
    return (e == 7);
`endif
  endfunction

  initial begin
    reset_n = 1'b0;
    raw_in  = 2'b11;
    clear_seen();

    // Reset held with inputs high: everything stays clear.
    tick(3);
    check_val("rst_level", level, 2'b00);
    check_val("rst_rise",  rise,  2'b00);
    check_val("rst_fall",  fall,  2'b00);
    check_val("rst_press", press, 2'b00);

    // Release: first rise exactly 7 edges later.
    reset_n = 1'b1;
    tick(6);
    check_val("rel_rise_e6",  rise,  2'b00);
    check_val("rel_level_e6", level, 2'b00);
    tick(1);
    check_val("rel_rise_e7",  rise,  2'b11);
    check_val("rel_level_e7", level, 2'b11);
    check_val("rel_press_e7", press, 2'b11);
    tick(1);
    check_val("rel_rise_e8",  rise,  2'b00);
    check_val("rel_level_e8", level, 2'b11);

    // Clean release of channel 0: one fall pulse after 7 edges.
    raw_in = 2'b10;
    tick(6);
    check_val("fall0_e6",       fall,  2'b00);
    check_val("fall0_level_e6", level, 2'b11);
    tick(1);
    check_val("fall0_e7",       fall,  2'b01);
    check_val("fall0_level_e7", level, 2'b10);
    check_val("fall0_rise_e7",  rise,  2'b00);
    tick(1);
    check_val("fall0_e8",       fall,  2'b00);

    raw_in = 2'b00;
    tick(7);
    check_val("fall1_e7",       fall,  2'b10);
    check_val("fall1_level_e7", level, 2'b00);
    tick(3);

    // Bounce on channel 0: 1,0,1,0 every two cycles, then steady 0.
    clear_seen();
    for (int i = 0; i < 8; i++) begin
      raw_in[0] = ((i / 2) % 2 == 0);
      tick_watch(1);
    end
    raw_in = 2'b00;
    tick_watch(12);
    check_val("bounce_level", seen_level, 2'b00);
    check_val("bounce_rise",  seen_rise,  2'b00);
    check_val("bounce_fall",  seen_fall,  2'b00);

    // Both channels rise together; async reset lands mid-CHK_H.
    raw_in = 2'b11;
    tick(4);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midh_rst_level", level, 2'b00);
    check_val("midh_rst_rise",  rise,  2'b00);
    tick(2);
    reset_n = 1'b1;
    clear_seen();
    tick_watch(6);
    check_val("midh_no_early_rise", seen_rise, 2'b00);
    tick(1);
    check_val("sim_rise_e7",  rise,  2'b11);
    check_val("sim_level_e7", level, 2'b11);
    tick(1);
    check_val("sim_rise_e8",  rise,  2'b00);

    // Async reset mid-CHK_L: level drops at once, no pulses afterwards.
    raw_in = 2'b00;
    tick(4);
    check_val("midl_level_pre", level, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midl_rst_level", level, 2'b00);
    tick(2);
    reset_n = 1'b1;
    clear_seen();
    tick_watch(10);
    check_val("midl_quiet_level", seen_level, 2'b00);
    check_val("midl_quiet_rise",  seen_rise,  2'b00);
    check_val("midl_quiet_fall",  seen_fall,  2'b00);

    // Hold channel 1 high, release after edge 41: rise at 7, fall at 48.
    raw_in = 2'b10;
    clear_seen();
    for (int e = 1; e <= 60; e++) begin
      tick(1);
      seen_rise = seen_rise | rise;
      seen_fall = seen_fall | fall;
      check_val($sformatf("rep_press1_e%0d", e), press[1], exp_press1(e));
      check_val($sformatf("rep_rise1_e%0d", e),  rise[1],  (e == 7));
      check_val($sformatf("rep_fall1_e%0d", e),  fall[1],  (e == 48));
      check_val($sformatf("rep_level1_e%0d", e), level[1], (e >= 7 && e < 48));
      if (e == 41) raw_in = 2'b00;
    end
    check_val("rep_ch0_rise", seen_rise[0], 1'b0);
    check_val("rep_ch0_fall", seen_fall[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
